axis_frame_arbiter: RTL and testbench
=====================================

// Module: axis_frame_arbiter
// PURPOSE
//  Frame-granular N:1 AXI4-Stream arbiter feeding one shared axis frame FIFO input.
//  Grants one source at a time and holds the grant until that source's tlast beat transfers.
//  Frames are never interleaved, so the downstream FIFO's drop/commit logic sees whole frames.
//  The arbitration policy is round-robin or fixed-priority, selected at compile time.
// PARAMETERS
//  S_COUNT     4  number of source ports (>=2)
//  DATA_WIDTH  8  tdata width per port
//  SEL_WIDTH   $clog2(S_COUNT)  grant index width (derived; do not override)
// PORTS
//  clk                 in   1                   clock
//  rst                 in   1                   reset, synchronous, active-high
//  input_axis_tdata    in   S_COUNT*DATA_WIDTH  port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  input_axis_tvalid   in   S_COUNT             per-port valid
//  input_axis_tready   out  S_COUNT             per-port ready
//  input_axis_tlast    in   S_COUNT             per-port end of frame
//  input_axis_tuser    in   S_COUNT             per-port bad-frame flag, passed through
//  output_axis_tdata   out  DATA_WIDTH          to FIFO
//  output_axis_tvalid  out  1                   to FIFO
//  output_axis_tready  in   1                   from FIFO
//  output_axis_tlast   out  1                   to FIFO
//  output_axis_tuser   out  1                   to FIFO
//  grant_valid         out  1                   a frame is in progress
//  grant_encoded       out  SEL_WIDTH           index of the granted port
// BEHAVIOUR
//  - Reset values: grant_valid=0, grant_encoded=0, state=IDLE, last_grant=S_COUNT-1.
//    input_axis_tready=0 and output_axis_tvalid=0 while in reset.
//  - States:
//    IDLE: if any tvalid is high, register the arbiter winner into grant_encoded,
//          set grant_valid=1, go to ACTIVE (1-cycle arbitration latency).
//          With no requests, stay in IDLE.
//    ACTIVE: output = combinational mux of the granted port.
//          output_axis_tvalid = tvalid[g].
//          tready[g] = output_axis_tready; all other tready are 0.
//          A transfer (tvalid[g] & output_axis_tready) with tlast[g]=1 goes to IDLE,
//          sets grant_valid=0 and last_grant=g.
//  - Each frame is followed by exactly one IDLE bubble cycle before the next grant.
//  - Granted port drops tvalid mid-frame: grant is held, output_axis_tvalid=0.
//    Other ports stay blocked.
//  - output_axis_tready low: tready[g]=0; data is held by the source per AXI rules.
//  - Single-beat frame (tlast on the first beat): IDLE->ACTIVE->IDLE. Legal.
//  - In IDLE, output_axis_tvalid=0 and all tready=0. No beat passes without a grant.
//  - Reset mid-frame: grant is dropped next edge. The downstream FIFO shares rst,
//    so no partial frame survives.
//  - Simultaneous requests are resolved by policy only; requests and tlast are not latched.
// CONFIGURATION
//  Macro AXIS_ARB_ROUND_ROBIN_EN:
//  - Defined: round-robin. The winner is the lowest requesting index > last_grant;
//    if none, the lowest requesting index overall (wrap-around).
//  - Undefined: fixed priority. The lowest requesting index always wins;
//    last_grant is unused and may be optimised away.
// STRUCTURE
//  - Shared package axis_defs: AXIS state encoding (ST_IDLE=1'b0, ST_ACTIVE=1'b1)
//    and the clog2 helper function.
//  - Sub-module axis_arb_core (combinational):
//    in  req[S_COUNT], last_grant[SEL_WIDTH]
//    out win_valid, win_idx[SEL_WIDTH]
//    Holds the policy selected by AXIS_ARB_ROUND_ROBIN_EN. The top level owns the FSM and mux.
// TESTING
//  1. Reset held 3 cycles -> grant_valid=0, output_axis_tvalid=0, input_axis_tready=4'b0000.
//  2. Port 2 sends a 3-beat frame {A1,A2,A3}, output_axis_tready=1:
//     grant_encoded=2 one cycle after tvalid, out A1,A2,A3 with tlast on A3,
//     grant_valid=0 on the next cycle.
//  3. Ports 0,1,3 each hold 2-beat frames:
//     RR grant order 0,1,3,0. Fixed priority with port 0 re-requesting: 0,0,...
//  4. output_axis_tready=0 for 2 cycles mid-frame on port 1 ->
//     input_axis_tready=4'b0000, output data stable, frame completes intact afterwards.
//  5. Port 1 granted, drops tvalid for 2 cycles mid-frame while port 0 requests ->
//     grant_encoded stays 1, tready[0]=0 until port 1's tlast.
//  6. rst asserted on beat 2 of a 4-beat frame -> next cycle grant_valid=0,
//     all tready=0. After release, a new request is granted normally.

Source files
------------

// File: rtl/axis_defs.sv
// Shared definitions for the AXI4-Stream frame arbiter: FSM state encoding and a width helper.
package axis_defs;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } axis_state_e;

  // Elaboration-time ceil(log2(n)); returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/axis_arb_core.sv
// Combinational winner selection for the frame arbiter.
// AXIS_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority (lowest index wins).
module axis_arb_core
  import axis_defs::*;
#(
  parameter int unsigned S_COUNT   = 4,
  parameter int unsigned SEL_WIDTH = clog2(S_COUNT)
) (
  input  logic [S_COUNT-1:0]   req,
  input  logic [SEL_WIDTH-1:0] last_grant,
  output logic                 win_valid,
  output logic [SEL_WIDTH-1:0] win_idx
);

`ifdef AXIS_ARB_ROUND_ROBIN_EN
  logic [S_COUNT-1:0] above;
  logic [S_COUNT-1:0] masked;

  always_comb begin
    above = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      above[i] = (SEL_WIDTH'(i) > last_grant);
    end
    masked = req & above;
    win_idx = '0;
    // Prefer requesters past the last grant, else wrap to the lowest requester.
    if (|masked) begin
      for (int i = S_COUNT - 1; i >= 0; i--) begin
        if (masked[i]) win_idx = SEL_WIDTH'(i);
      end
    end else begin
      for (int i = S_COUNT - 1; i >= 0; i--) begin
        if (req[i]) win_idx = SEL_WIDTH'(i);
      end
    end
    win_valid = |req;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    win_idx = '0;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      if (req[i]) win_idx = SEL_WIDTH'(i);
    end
    win_valid = |req;
  end
`endif

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular N:1 AXI4-Stream arbiter; a grant is held until the granted port's tlast beat.
// Policy macro: AXIS_ARB_ROUND_ROBIN_EN (defined = round-robin, undefined = fixed priority).
module axis_frame_arbiter
  import axis_defs::*;
#(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SEL_WIDTH  = clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [S_COUNT-1:0]            input_axis_tvalid,
  output logic [S_COUNT-1:0]            input_axis_tready,
  input  logic [S_COUNT-1:0]            input_axis_tlast,
  input  logic [S_COUNT-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]         output_axis_tdata,
  output logic                          output_axis_tvalid,
  input  logic                          output_axis_tready,
  output logic                          output_axis_tlast,
  output logic                          output_axis_tuser,
  output logic                          grant_valid,
  output logic [SEL_WIDTH-1:0]          grant_encoded
);

  axis_state_e          state_q;
  logic [SEL_WIDTH-1:0] last_grant_q;
  logic                 win_valid;
  logic [SEL_WIDTH-1:0] win_idx;
  logic                 active;
  logic                 sel_valid;
  logic                 sel_last;

  axis_arb_core #(
    .S_COUNT   (S_COUNT),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arb_core (
    .req        (input_axis_tvalid),
    .last_grant (last_grant_q),
    .win_valid  (win_valid),
    .win_idx    (win_idx)
  );

  // rst also gates the handshake so nothing transfers while reset is held.
  assign active = (state_q == ST_ACTIVE) && !rst;

  always_comb begin
    output_axis_tdata = '0;
    sel_valid         = 1'b0;
    sel_last          = 1'b0;
    output_axis_tuser = 1'b0;
    input_axis_tready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_encoded == SEL_WIDTH'(i)) begin
        output_axis_tdata    = input_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid            = input_axis_tvalid[i];
        sel_last             = input_axis_tlast[i];
        output_axis_tuser    = input_axis_tuser[i];
        input_axis_tready[i] = active && output_axis_tready;
      end
    end
    output_axis_tvalid = active && sel_valid;
    output_axis_tlast  = sel_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      last_grant_q  <= SEL_WIDTH'(S_COUNT - 1);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            grant_encoded <= win_idx;
            grant_valid   <= 1'b1;
            state_q       <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (sel_valid && output_axis_tready && sel_last) begin
            grant_valid  <= 1'b0;
            last_grant_q <= grant_encoded;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed self-checking bench for axis_frame_arbiter (S_COUNT=4, DATA_WIDTH=8).
module tb_axis_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [3:0]  in_last = '0;
  logic [3:0]  in_user = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        out_user;
  logic        gnt_valid;
  logic [1:0]  gnt_idx;

  int n_tests = 0;
  int n_fail  = 0;

  axis_frame_arbiter #(
    .S_COUNT    (4),
    .DATA_WIDTH (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_data),
    .input_axis_tvalid  (in_valid),
    .input_axis_tready  (in_ready),
    .input_axis_tlast   (in_last),
    .input_axis_tuser   (in_user),
    .output_axis_tdata  (out_data),
    .output_axis_tvalid (out_valid),
    .output_axis_tready (out_ready),
    .output_axis_tlast  (out_last),
    .output_axis_tuser  (out_user),
    .grant_valid        (gnt_valid),
    .grant_encoded      (gnt_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_data(input int port, input logic [7:0] d);
    in_data[port*8 +: 8] = d;
  endtask

  // One 2-beat frame from the expected winner; entered during the IDLE bubble, all
  // requesters valid. Beat data is 8'h{port,beat}; the port re-arms beat 0 afterwards.
  task automatic frame2(input string tag, input int exp_port);
    settle();
    chk({tag, "_bubble"}, 32'(gnt_valid), 32'd0);
    tick();
    settle();
    chk({tag, "_grant"}, 32'(gnt_idx), 32'(exp_port));
    chk({tag, "_b0"}, 32'(out_data), 32'(exp_port * 16));
    tick();
    set_data(exp_port, 8'(exp_port * 16 + 1));
    in_last[exp_port] = 1'b1;
    settle();
    chk({tag, "_b1"}, 32'({out_last, out_data}), 32'(256 + exp_port * 16 + 1));
    tick();
    set_data(exp_port, 8'(exp_port * 16));
    in_last[exp_port] = 1'b0;
  endtask

  initial begin
    // 1: reset held 3 cycles
    rst = 1'b1;
    tick();
    tick();
    tick();
    settle();
    chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
    chk("rst_gnt_idx", 32'(gnt_idx), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;

    // 2: port 2, 3-beat frame A1 A2 A3
    tick();
    in_valid = 4'b0100;
    set_data(2, 8'hA1);
    in_user[2] = 1'b1;
    settle();
    chk("t2_idle_gnt", 32'(gnt_valid), 32'd0);
    chk("t2_idle_ready", 32'(in_ready), 32'h0);
    chk("t2_idle_ovalid", 32'(out_valid), 32'd0);
    tick();
    settle();
    chk("t2_gnt", 32'({gnt_valid, gnt_idx}), 32'b110);
    chk("t2_a1", 32'({out_valid, out_last, out_user, out_data}), 32'h5A1);
    chk("t2_ready", 32'(in_ready), 32'b0100);
    tick();
    set_data(2, 8'hA2);
    settle();
    chk("t2_a2", 32'({out_last, out_data}), 32'h0A2);
    tick();
    set_data(2, 8'hA3);
    in_last[2] = 1'b1;
    settle();
    chk("t2_a3", 32'({out_last, out_data}), 32'h1A3);
    tick();
    in_valid = 4'b0000;
    in_last = '0;
    in_user = '0;
    settle();
    chk("t2_end_gnt", 32'(gnt_valid), 32'd0);
    chk("t2_end_ready", 32'(in_ready), 32'h0);

    // 3: ports 0,1,3 with 2-beat frames, fresh reset so last_grant=3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = 0; p < 4; p++) set_data(p, 8'(p * 16));
    in_valid = 4'b1011;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
    frame2("t3_f0", 0);
    frame2("t3_f1", 1);
    frame2("t3_f2", 3);
    frame2("t3_f3", 0);
`else
    frame2("t3_f0", 0);
    frame2("t3_f1", 0);
    frame2("t3_f2", 0);
    frame2("t3_f3", 0);
`endif
    in_valid = 4'b0000;

    // 4: output backpressure mid-frame on port 1
    tick();
    in_valid = 4'b0010;
    set_data(1, 8'hB1);
    tick();
    settle();
    chk("t4_gnt", 32'({gnt_valid, gnt_idx}), 32'b101);
    out_ready = 1'b0;
    settle();
    chk("t4_stall_ready", 32'(in_ready), 32'h0);
    chk("t4_stall_data", 32'({out_valid, out_data}), 32'h1B1);
    tick();
    settle();
    chk("t4_stall2_data", 32'({out_valid, out_data}), 32'h1B1);
    chk("t4_stall2_ready", 32'(in_ready), 32'h0);
    tick();
    out_ready = 1'b1;
    settle();
    chk("t4_resume", 32'({in_ready, out_data}), 32'h2B1);
    tick();
    set_data(1, 8'hB2);
    settle();
    chk("t4_b2", 32'(out_data), 32'hB2);
    tick();
    set_data(1, 8'hB3);
    in_last[1] = 1'b1;
    settle();
    chk("t4_b3", 32'({out_last, out_data}), 32'h1B3);
    tick();
    in_valid = 4'b0000;
    in_last = '0;
    settle();
    chk("t4_end_gnt", 32'(gnt_valid), 32'd0);

    // 5: port 1 drops tvalid mid-frame while port 0 requests
    tick();
    in_valid = 4'b0010;
    set_data(1, 8'hC1);
    tick();
    in_valid[0] = 1'b1;
    set_data(0, 8'hD0);
    in_last[0] = 1'b1;
    settle();
    chk("t5_gnt", 32'({gnt_valid, gnt_idx}), 32'b101);
    chk("t5_ready", 32'(in_ready), 32'b0010);
    tick();
    in_valid[1] = 1'b0;
    settle();
    chk("t5_gap_ovalid", 32'(out_valid), 32'd0);
    chk("t5_gap_ready", 32'(in_ready), 32'b0010);
    tick();
    settle();
    chk("t5_gap2_gnt", 32'({gnt_valid, gnt_idx}), 32'b101);
    chk("t5_gap2_ready0", 32'(in_ready[0]), 32'd0);
    tick();
    in_valid[1] = 1'b1;
    set_data(1, 8'hC2);
    in_last[1] = 1'b1;
    settle();
    chk("t5_c2", 32'({out_valid, out_last, out_data}), 32'h3C2);
    tick();
    in_valid[1] = 1'b0;
    in_last[1] = 1'b0;
    settle();
    chk("t5_bubble", 32'({gnt_valid, in_ready}), 32'h0);
    tick();
    settle();
    chk("t5_p0_gnt", 32'({gnt_valid, gnt_idx}), 32'b100);
    chk("t5_p0_data", 32'({out_valid, out_last, out_data}), 32'h3D0);
    tick();
    in_valid = 4'b0000;
    in_last = '0;

    // 6: reset on beat 2 of a 4-beat frame from port 3
    tick();
    in_valid = 4'b1000;
    set_data(3, 8'hE1);
    tick();
    settle();
    chk("t6_gnt", 32'({gnt_valid, gnt_idx}), 32'b111);
    tick();
    set_data(3, 8'hE2);
    rst = 1'b1;
    tick();
    settle();
    chk("t6_rst_gnt", 32'(gnt_valid), 32'd0);
    chk("t6_rst_ready", 32'({out_valid, in_ready}), 32'h0);
    rst = 1'b0;
    in_valid = 4'b0100;
    set_data(2, 8'h5C);
    settle();
    chk("t6_post_idle", 32'(gnt_valid), 32'd0);
    tick();
    settle();
    chk("t6_post_gnt", 32'({gnt_valid, gnt_idx}), 32'b110);
    chk("t6_post_data", 32'({out_valid, out_data}), 32'h15C);
    in_valid = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
